// File: rtl/dout_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : dout_seq_checker
// Description : Checks three successive DFF-output samples against a
//               programmable 3-byte pattern at a programmable cycle spacing.
//               Reports pass/fail pulses, failure detail and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dout_seq_checker #(
    parameter int DATA_W = 8,
    parameter int GAP_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              start_vld,
    input  logic [DATA_W-1:0] pat0,
    input  logic [DATA_W-1:0] pat1,
    input  logic [DATA_W-1:0] pat2,
    input  logic [GAP_W-1:0]  gap,
    output logic              busy,
    output logic              match_pulse,
    output logic              fail_pulse,
    output logic [1:0]        fail_idx,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_CHK1 = 2'd1;
    localparam logic [1:0]       c_ST_CHK2 = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] c_ONE     = GAP_W'(1);

    logic [1:0]        r_state, w_state_nxt;
    logic [GAP_W-1:0]  r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0]  r_gap, w_gap_nxt;
    logic [DATA_W-1:0] r_pat1, w_pat1_nxt;
    logic [DATA_W-1:0] r_pat2, w_pat2_nxt;
    logic [GAP_W-1:0]  w_eff_gap;
    logic              w_match;
    logic              w_fail;
    logic [1:0]        w_fail_idx;

    logic              r_match_pulse;
    logic              r_fail_pulse;
    logic [1:0]        r_fail_idx;
    logic [DATA_W-1:0] r_fail_data;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_pat1_nxt  = r_pat1;
        w_pat2_nxt  = r_pat2;
        w_match     = 1'b0;
        w_fail      = 1'b0;
        w_fail_idx  = 2'd0;
        w_eff_gap   = (gap == '0) ? c_ONE : gap;
        case (r_state)
            c_ST_IDLE: begin
                // The arm cycle itself is the stage-0 sample
                if (start_vld) begin
                    w_gap_nxt  = w_eff_gap;
                    w_pat1_nxt = pat1;
                    w_pat2_nxt = pat2;
                    if (din == pat0) begin
                        w_cnt_nxt   = w_eff_gap - c_ONE;
                        w_state_nxt = c_ST_CHK1;
                    end else begin
                        w_fail     = 1'b1;
                        w_fail_idx = 2'd0;
                    end
                end
            end
            c_ST_CHK1: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (din == r_pat1) begin
                    w_cnt_nxt   = r_gap - c_ONE;
                    w_state_nxt = c_ST_CHK2;
                end else begin
                    w_fail      = 1'b1;
                    w_fail_idx  = 2'd1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_CHK2: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (din == r_pat2) begin
                    w_match     = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_fail      = 1'b1;
                    w_fail_idx  = 2'd2;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_gap         <= '0;
            r_pat1        <= '0;
            r_pat2        <= '0;
            r_match_pulse <= 1'b0;
            r_fail_pulse  <= 1'b0;
            r_fail_idx    <= 2'd0;
            r_fail_data   <= '0;
            r_match_cnt   <= '0;
            r_fail_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_gap         <= w_gap_nxt;
            r_pat1        <= w_pat1_nxt;
            r_pat2        <= w_pat2_nxt;
            r_match_pulse <= w_match;
            r_fail_pulse  <= w_fail;
            if (w_fail) begin
                r_fail_idx  <= w_fail_idx;
                r_fail_data <= din;
            end
            if (w_match && (r_match_cnt != c_CNT_MAX)) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
            if (w_fail && (r_fail_cnt != c_CNT_MAX)) begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
            end
        end
    end

    // Busy is a pure decode of the state register, so it drops on the result cycle
    assign busy        = (r_state != c_ST_IDLE);
    assign match_pulse = r_match_pulse;
    assign fail_pulse  = r_fail_pulse;
    assign fail_idx    = r_fail_idx;
    assign fail_data   = r_fail_data;
    assign match_cnt   = r_match_cnt;
    assign fail_cnt    = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dout_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dout_seq_checker
// Description : Directed, table-driven self-checking bench for dout_seq_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dout_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       start_vld;
    logic [7:0] pat0, pat1, pat2;
    logic [3:0] gap;
    logic       busy, match_pulse, fail_pulse;
    logic [1:0] fail_idx;
    logic [7:0] fail_data, match_cnt, fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dout_seq_checker #(.DATA_W(8), .GAP_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .start_vld  (start_vld),
        .pat0       (pat0),
        .pat1       (pat1),
        .pat2       (pat2),
        .gap        (gap),
        .busy       (busy),
        .match_pulse(match_pulse),
        .fail_pulse (fail_pulse),
        .fail_idx   (fail_idx),
        .fail_data  (fail_data),
        .match_cnt  (match_cnt),
        .fail_cnt   (fail_cnt)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] din;
        logic [3:0] gap;
        logic       busy;
        logic       mp;
        logic       fp;
        logic [1:0] idx;
        logic [7:0] fdata;
        logic [7:0] mc;
        logic [7:0] fc;
    } vec_t;

    vec_t vecs[19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic mp, input logic fp,
                           input logic [1:0] idx, input logic [7:0] fd,
                           input logic [7:0] mc, input logic [7:0] fc);
        chk({tag, ".busy"},        int'(busy),        int'(b));
        chk({tag, ".match_pulse"}, int'(match_pulse), int'(mp));
        chk({tag, ".fail_pulse"},  int'(fail_pulse),  int'(fp));
        chk({tag, ".fail_idx"},    int'(fail_idx),    int'(idx));
        chk({tag, ".fail_data"},   int'(fail_data),   int'(fd));
        chk({tag, ".match_cnt"},   int'(match_cnt),   int'(mc));
        chk({tag, ".fail_cnt"},    int'(fail_cnt),    int'(fc));
    endtask

    initial begin
        //          rst start din    gap  | busy mp fp idx fdata  mc  fc
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'd0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'd0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'd0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'h02, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'd0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h03, 4'd1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'd1, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'd1, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'd1, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 8'h05, 4'd1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h05, 8'd1, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h05, 8'd1, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 8'd1, 8'd2};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'd1, 8'd2};
        vecs[11] = '{1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'd1, 8'd2};
        vecs[12] = '{1'b0, 1'b0, 8'h02, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'd1, 8'd2};
        vecs[13] = '{1'b0, 1'b0, 8'h07, 4'd1, 1'b0, 1'b0, 1'b1, 2'd2, 8'h07, 8'd1, 8'd3};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 2'd2, 8'h07, 8'd1, 8'd3};
        vecs[15] = '{1'b0, 1'b1, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 2'd2, 8'h07, 8'd1, 8'd3};
        vecs[16] = '{1'b0, 1'b0, 8'h02, 4'd0, 1'b1, 1'b0, 1'b0, 2'd2, 8'h07, 8'd1, 8'd3};
        vecs[17] = '{1'b0, 1'b0, 8'h03, 4'd0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h07, 8'd2, 8'd3};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h07, 8'd2, 8'd3};

        rst = 1'b1; start_vld = 1'b0; din = 8'h00;
        pat0 = 8'h01; pat1 = 8'h02; pat2 = 8'h03; gap = 4'd1;

        for (int i = 0; i < 19; i++) begin
            rst       = vecs[i].rst;
            start_vld = vecs[i].start;
            din       = vecs[i].din;
            gap       = vecs[i].gap;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].mp, vecs[i].fp,
                    vecs[i].idx, vecs[i].fdata, vecs[i].mc, vecs[i].fc);
        end

        // gap=3: compares at T, T+3, T+6; off-cycle samples must be ignored
        gap = 4'd3;
        for (int i = 0; i < 7; i++) begin
            start_vld = (i == 0);
            din = (i < 3) ? 8'h01 : ((i < 6) ? 8'h02 : 8'h03);
            step();
            chk($sformatf("gap3.busy%0d", i),  int'(busy),        int'(i < 6));
            chk($sformatf("gap3.match%0d", i), int'(match_pulse), int'(i == 6));
            chk($sformatf("gap3.fail%0d", i),  int'(fail_pulse),  0);
        end
        start_vld = 1'b0; din = 8'h00;
        step();
        chk_all("gap3.after", 1'b0, 1'b0, 1'b0, 2'd2, 8'h07, 8'd3, 8'd3);

        // start_vld held: ignored while busy, re-arm on the result cycle
        gap = 4'd1;
        for (int i = 0; i < 6; i++) begin
            start_vld = 1'b1;
            din = 8'(i % 3 + 1);
            step();
            chk($sformatf("held.busy%0d", i),  int'(busy),        int'(i % 3 != 2));
            chk($sformatf("held.match%0d", i), int'(match_pulse), int'(i % 3 == 2));
        end
        start_vld = 1'b0; din = 8'h00;
        step();
        chk_all("held.after", 1'b0, 1'b0, 1'b0, 2'd2, 8'h07, 8'd5, 8'd3);

        // Configuration changes after arming must not affect the check
        start_vld = 1'b1; din = 8'h01;
        step();
        start_vld = 1'b0; pat1 = 8'h55; pat2 = 8'h99; gap = 4'd5; din = 8'h02;
        step();
        chk("latch.busy1", int'(busy), 1);
        din = 8'h03;
        step();
        chk_all("latch.result", 1'b0, 1'b1, 1'b0, 2'd2, 8'h07, 8'd6, 8'd3);
        pat1 = 8'h02; pat2 = 8'h03; gap = 4'd1; din = 8'h00;
        step();

        // Reset while in CHK2 aborts silently and clears everything
        start_vld = 1'b1; din = 8'h01;
        step();
        start_vld = 1'b0; din = 8'h02;
        step();
        chk("rst.busy_chk2", int'(busy), 1);
        rst = 1'b1; din = 8'h03;
        step();
        chk_all("rst.during", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'd0, 8'd0);
        rst = 1'b0; din = 8'h00;
        step();
        chk_all("rst.after", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'd0, 8'd0);

        // 260 back-to-back passing checks: match_cnt saturates at 255
        for (int k = 0; k < 260; k++) begin
            for (int j = 0; j < 3; j++) begin
                start_vld = (j == 0);
                din = 8'(j + 1);
                step();
            end
            chk($sformatf("sat.mc%0d", k), int'(match_cnt), (k + 1 > 255) ? 255 : k + 1);
        end
        start_vld = 1'b0; din = 8'h00;
        step();
        chk_all("sat.final", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'd255, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dout_seq_checker.md
Name: dout_seq_checker

Overview:
- Hardware receive-side checker for the 8-bit registered data path (`clk`/`rst`/`din`/`dout` DFF stage).
- Consumes the DFF output stream. When armed, compares three successive samples against a programmable 3-byte pattern at a programmable cycle spacing.
- Reports pass/fail pulses, failure detail and saturating event counters. It is the synthesizable replacement for the bench-side sequence assertion, usable on silicon/FPGA.

Parameters:
- DATA_W, 8, width of monitored data and pattern bytes.
- GAP_W, 4, width of the inter-sample spacing field.
- CNT_W, 8, width of match/fail event counters.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_W  monitored stream (DFF dout).
- start_vld  input  1  arm request; sampled each cycle.
- pat0  input  DATA_W  expected first byte.
- pat1  input  DATA_W  expected second byte.
- pat2  input  DATA_W  expected third byte.
- gap  input  GAP_W  cycles between compares; 0 is treated as 1.
- busy  output  1  check in progress.
- match_pulse  output  1  one-cycle pulse: full pattern matched.
- fail_pulse  output  1  one-cycle pulse: a compare mismatched.
- fail_idx  output  2  stage that failed (0/1/2); held until the next fail.
- fail_data  output  DATA_W  `din` value at the failing compare; held.
- match_cnt  output  CNT_W  saturating count of matches.
- fail_cnt  output  CNT_W  saturating count of fails.

Behaviour:
- **Reset.** All outputs are 0 at the clock edge where `rst`=1. The FSM goes to IDLE and the latched pattern/gap are cleared. Reset mid-check aborts silently: no pulse, and counters are cleared.
- **FSM states:** IDLE, CHK1, CHK2.
- **IDLE:**
  - If `start_vld`=1: latch `pat1`, `pat2` and eff_gap = (`gap`==0 ? 1 : `gap`).
  - In the same cycle, compare `din` to `pat0` (overlapping implication: the arm cycle is the stage-0 sample).
  - Equal: load the spacing counter with eff_gap-1, go to CHK1, `busy`=1 from the next cycle.
  - Unequal: fail on stage 0 and stay in IDLE.
- **CHK1:**
  - Spacing counter decrements each cycle. When it reaches 0, compare `din` to latched `pat1`.
  - Equal: reload the counter and go to CHK2.
  - Unequal: fail on stage 1 and go to IDLE.
- **CHK2:**
  - Same timing as CHK1. Compare to latched `pat2`.
  - Equal: match and go to IDLE.
  - Unequal: fail on stage 2 and go to IDLE.
- **Timing.** Arm at cycle T → compares at T, T+g, T+2g (g = eff_gap). `match_pulse`/`fail_pulse` is registered and high for exactly one cycle at compare cycle +1. `busy` is high from T+1 through T+2g inclusive, low on the result cycle.
- **On a fail:** `fail_idx` and `fail_data` update on the same edge as `fail_pulse`. Otherwise they are held.
- **Mutual exclusion.** `match_pulse` and `fail_pulse` are never high together.
- **Latched configuration.** `pat1`/`pat2`/`gap` changes while `busy` have no effect on the check in progress.
- **`start_vld` while `busy`:** ignored, no re-arm and no counting. `start_vld` on the result cycle (busy=0, FSM in IDLE) is accepted: back-to-back checks.
- **Counters.** Increment by 1 on each pulse. Saturate at 2^CNT_W-1, with no wrap.
- **Data path.** Pure equality compare, no arithmetic. No combinational path from inputs to outputs.

Test Plan:
1. **Basic match:** reset, then gap=1, pat=01/02/03; drive `din`=01,02,03 on consecutive cycles with `start_vld` on the first → `match_pulse` one cycle after the 03 sample; `busy` high 2 cycles; match_cnt=1; fail_cnt=0.
2. **Stage-1 failure:** same config, `din`=01,05 → `fail_pulse` one cycle after the 05 sample; fail_idx=1, fail_data=0x05; FSM in IDLE; fail_cnt=1.
3. **Spacing and gap=0:**
   - gap=3, `din` holding 01 for 3 cycles, then 02 for 3, then 03 → match with the pulse at T+7.
   - Repeat with gap=0 → behaves as gap=1.
4. **Arm rules:**
   - `start_vld` with `din`=0x00, pat0=0x01 → immediate stage-0 fail, fail_idx=0, busy never asserts.
   - `start_vld` held high throughout a check → ignored while busy; a new arm is accepted on the result cycle (back-to-back checks).
5. **Reset and latching:**
   - Assert `rst` one cycle while in CHK2 → no pulse, all outputs and counters 0.
   - Change `pat2` mid-check → the latched value is still used.
6. **Saturation:** CNT_W=8, run 260 passing checks → match_cnt stops at 255; fail_cnt unaffected.
